irq_controller: RTL

- External interrupt source for the single-cycle LEGv8 core.
- Collects device interrupt lines, latches them as pending, and arbitrates by fixed priority.
- Drives ExtIRQ into the core controller and holds it until the core returns ExtIAck; then waits for ERet before raising the next request.
- Presents the serviced source index on irq_id for the exception handler; no nesting.

---
 rtl/irq_pkg.sv | 14 +
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_controller.sv | 98 +++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types for the external interrupt controller and the core's exception logic.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Exception-cause codes written into ESTATUS by the core controller.
    localparam logic [3:0] ESTATUS_EXTIRQ = 4'b0001;
    localparam logic [3:0] ESTATUS_BADOP  = 4'b0010;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; purely combinational.
module irq_prio_enc #(
    parameter int N_SRC = 8,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    output logic [ID_W-1:0]  id_o,
    output logic             vld_o
);

    always_comb begin
        id_o  = '0;
        vld_o = |req_i;
        // Scan downwards so the lowest set index is the last write.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = i[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// External interrupt source for the LEGv8 core: pending latch, fixed-priority pick,
// and a REQ/SERVICE handshake with the core controller (no nesting).
module irq_controller
    import irq_pkg::*;
#(
    parameter int               N_SRC     = 8,
    parameter int               ID_W      = $clog2(N_SRC),
    parameter logic [N_SRC-1:0] EDGE_MASK = {N_SRC{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] irq_mask,
    output logic             ExtIRQ,
    input  logic             ExtIAck,
    input  logic             ERet,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] irq_pending,
    output logic             in_service
);

    irq_state_t       state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] prev_src_q;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;

    logic [ID_W-1:0]  win_id;
    logic             win_vld;
    logic             ack_fire;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_i (pending_q & irq_mask),
        .id_o  (win_id),
        .vld_o (win_vld)
    );

    assign ack_fire = (state_q == REQ) && ExtIAck;

    // A new edge on the source being acknowledged wins over the clear.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (EDGE_MASK[i]) begin
                pending_d[i] = (irq_src[i] & ~prev_src_q[i]) |
                               (pending_q[i] & ~(ack_fire && (irq_id_q == i[ID_W-1:0])));
            end else begin
                pending_d[i] = irq_src[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    irq_id_d = win_id;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (ExtIAck) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (ERet) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            prev_src_q <= '0;
            irq_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            prev_src_q <= irq_src;
            irq_id_q   <= irq_id_d;
        end
    end

    assign ExtIRQ      = (state_q == REQ);
    assign in_service  = (state_q == SERVICE);
    assign irq_id      = irq_id_q;
    assign irq_pending = pending_q;

endmodule
